// File: rtl/cbs_result_writer.sv
`timescale 1ns/1ps
// cbs_result_writer: requantizes 8 lane sums to bytes, packs them into a
// 64-bit word and writes the words to the feature-map RAM in raster order.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; no input accepted
// RUN    | accepting lane groups until the whole map has been taken in
// FLUSH  | all groups taken in; draining the FIFO to the RAM
// DONE   | last word written; done pulses for this one cycle
module cbs_result_writer #(
  parameter int                COLS   = 80,
  parameter int                ROWS   = 640,
  parameter int                ADDR_W = 20,
  parameter int                SHIFT  = 4,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_res,
  input  logic [7:0]        in_carry,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  localparam int TOTAL = COLS * ROWS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sat_q, sat_d;
  logic [63:0]       fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q;

  logic        start_ok, push, pop, last_word, clip_any;
  logic [63:0] pack;
  logic [16:0] lane_v, lane_q;

  assign start_ok  = (state_q == S_IDLE) && start;
  assign mem_we    = (cnt_q != 2'd0);
  assign pop       = mem_we && mem_ready;
  // The remaining-groups down-counter reaching zero closes the input side.
  assign in_ready  = (state_q == S_RUN) && (cnt_q < 2'd2) && (rem_q != '0);
  assign push      = in_valid && in_ready;
  assign last_word = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));
  assign mem_addr  = addr_q;
  assign mem_data  = fifo_q[rd_ptr_q];
  assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);
  assign sat_flag  = sat_q;

  // Requantize each 17-bit lane (carry:res) to an unsigned byte, clipping at 255.
  always_comb begin
    pack     = '0;
    clip_any = 1'b0;
    lane_v   = '0;
    lane_q   = '0;
    for (int k = 0; k < 8; k++) begin
      lane_v = {in_carry[7-k], in_res[127-16*k -: 16]};
      lane_q = lane_v >> SHIFT;
      if (lane_q > 17'd255) begin
        pack[63-8*k -: 8] = 8'hFF;
        clip_any          = 1'b1;
      end else begin
        pack[63-8*k -: 8] = lane_q[7:0];
      end
    end
  end

  // Next-state and counter updates for the sequencer, write address and sat flag.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    sat_d   = sat_q;

    if (start_ok) begin
      rem_d  = CNT_W'(TOTAL);
      col_d  = '0;
      row_d  = '0;
      addr_d = BASE;
      sat_d  = 1'b0;
    end

    if (push) begin
      rem_d = rem_q - CNT_W'(1);
      if (clip_any) sat_d = 1'b1;
    end

    if (pop) begin
      if (last_word) begin
        col_d  = '0;
        row_d  = '0;
        addr_d = BASE;
      end else if (col_q == COL_W'(COLS - 1)) begin
        col_d  = '0;
        row_d  = row_q + ROW_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (push && (rem_q == CNT_W'(1))) state_d = S_FLUSH;
      S_FLUSH: if (pop && last_word) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, counters and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= BASE;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      sat_q   <= sat_d;
    end
  end

  // Two-entry write FIFO; the packed word is registered straight into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= pack;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_cbs_result_writer.sv
`timescale 1ns/1ps
// Bench for cbs_result_writer: one default-size instance (A) and one 4x2
// instance (B) for the full-map sequence. Expected writes are queued when a
// group is accepted and popped by a monitor when the RAM port transfers.
module tb_cbs_result_writer;

  localparam int TOTAL_A = 80 * 640;
  localparam int TOTAL_B = 4 * 2;
  localparam int DIV     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         start_a, in_valid_a, in_ready_a, mem_we_a, mem_ready_a, busy_a, done_a, sat_a;
  logic [127:0] in_res_a;
  logic [7:0]   in_carry_a;
  logic [19:0]  mem_addr_a;
  logic [63:0]  mem_data_a;

  logic         start_b, in_valid_b, in_ready_b, mem_we_b, mem_ready_b, busy_b, done_b, sat_b;
  logic [127:0] in_res_b;
  logic [7:0]   in_carry_b;
  logic [19:0]  mem_addr_b;
  logic [63:0]  mem_data_b;

  cbs_result_writer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_res(in_res_a), .in_carry(in_carry_a), .mem_we(mem_we_a), .mem_ready(mem_ready_a),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a), .busy(busy_a), .done(done_a), .sat_flag(sat_a)
  );

  cbs_result_writer #(.COLS(4), .ROWS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_res(in_res_b), .in_carry(in_carry_b), .mem_we(mem_we_b), .mem_ready(mem_ready_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .busy(busy_b), .done(done_b), .sat_flag(sat_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference quantizer: plain integer arithmetic on each lane.
  function automatic logic [64:0] ref_q(input logic [127:0] r, input logic [7:0] c);
    logic [63:0] d;
    logic        s;
    int unsigned v, q;
    d = '0;
    s = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v = (c[7-k] ? 32'd65536 : 32'd0) + 32'(r[127-16*k -: 16]);
      q = v / DIV;
      if (q > 255) begin
        s = 1'b1;
        d[63-8*k -: 8] = 8'hFF;
      end else begin
        d[63-8*k -: 8] = q[7:0];
      end
    end
    return {s, d};
  endfunction

  function automatic logic [127:0] rand_res();
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'($urandom_range(0, 65535));
    return r;
  endfunction

  function automatic logic [127:0] fill_res(input logic [15:0] v);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  // Scoreboard / monitor for instance A
  logic [83:0] q_a[$];
  logic [83:0] e_a;
  logic [64:0] r_a;
  int          widx_a = 0;
  int          writes_a = 0;
  logic        sat_exp_a = 1'b0;
  logic        hold_vld_a = 1'b0;
  logic [19:0] hold_addr_a;
  logic [63:0] hold_data_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      widx_a     = 0;
      sat_exp_a  = 1'b0;
      hold_vld_a = 1'b0;
    end else begin
      chk("sat_flag_a", 64'(sat_a), 64'(sat_exp_a));
      if (hold_vld_a && mem_we_a) begin
        chk("hold_addr_a", 64'(mem_addr_a), 64'(hold_addr_a));
        chk("hold_data_a", mem_data_a, hold_data_a);
      end
      hold_vld_a  = mem_we_a && !mem_ready_a;
      hold_addr_a = mem_addr_a;
      hold_data_a = mem_data_a;
      if (mem_we_a && mem_ready_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write_a: addr %h data %h with no group pending", mem_addr_a, mem_data_a);
        end else begin
          e_a = q_a.pop_front();
          chk("wr_addr_a", 64'(mem_addr_a), 64'(e_a[83:64]));
          chk("wr_data_a", mem_data_a, e_a[63:0]);
          writes_a++;
        end
      end
      if (start_a && !busy_a && !done_a) sat_exp_a = 1'b0;
      if (in_valid_a && in_ready_a) begin
        r_a = ref_q(in_res_a, in_carry_a);
        q_a.push_back({20'(widx_a % TOTAL_A), r_a[63:0]});
        widx_a++;
        if (r_a[64]) sat_exp_a = 1'b1;
      end
    end
  end

  // Scoreboard / monitor for instance B
  logic [83:0] q_b[$];
  logic [83:0] e_b;
  logic [64:0] r_b;
  int          widx_b = 0;
  int          writes_b = 0;
  int          done_cnt_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_b.delete();
      widx_b = 0;
    end else begin
      if (done_b) done_cnt_b++;
      if (mem_we_b && mem_ready_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write_b: addr %h data %h with no group pending", mem_addr_b, mem_data_b);
        end else begin
          e_b = q_b.pop_front();
          chk("wr_addr_b", 64'(mem_addr_b), 64'(e_b[83:64]));
          chk("wr_data_b", mem_data_b, e_b[63:0]);
          writes_b++;
        end
      end
      if (in_valid_b && in_ready_b) begin
        r_b = ref_q(in_res_b, in_carry_b);
        q_b.push_back({20'(widx_b % TOTAL_B), r_b[63:0]});
        widx_b++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [127:0] r, input logic [7:0] c);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    in_res_a   = r;
    in_carry_a = c;
    in_valid_a = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready_a;
      cyc();
      t++;
    end
    in_valid_a = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_a_timeout: got no in_ready expected accept within 100 cycles");
    end
  endtask

  task automatic send_b(input logic [127:0] r, input logic [7:0] c);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    in_res_b   = r;
    in_carry_b = c;
    in_valid_b = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready_b;
      cyc();
      t++;
    end
    in_valid_b = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_b_timeout: got no in_ready expected accept within 100 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    logic [127:0] r;

    rst_n = 1'b0;
    start_a = 0; in_valid_a = 0; in_res_a = '0; in_carry_a = '0; mem_ready_a = 1;
    start_b = 0; in_valid_b = 0; in_res_b = '0; in_carry_b = '0; mem_ready_b = 1;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_a), 64'd0);
    chk("rst_mem_we",   64'(mem_we_a),   64'd0);
    chk("rst_mem_addr", 64'(mem_addr_a), 64'd0);
    chk("rst_mem_data", mem_data_a,      64'd0);
    chk("rst_busy",     64'(busy_a),     64'd0);
    chk("rst_done",     64'(done_a),     64'd0);
    chk("rst_sat",      64'(sat_a),      64'd0);
    cyc();

    // First group: one-cycle latency to the RAM port
    start_a = 1'b1; cyc(); start_a = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy_a), 64'd1);
    cyc();
    send_a(fill_res(16'h0100), 8'h00);
    @(negedge clk);
    chk("lat_mem_we",   64'(mem_we_a),   64'd1);
    chk("lat_mem_addr", 64'(mem_addr_a), 64'd0);
    chk("lat_mem_data", mem_data_a,      64'h1010_1010_1010_1010);
    cyc();

    // q == 255 exactly is not a clip
    send_a(fill_res(16'h0FF0), 8'h00);
    @(negedge clk);
    chk("exact255_data", mem_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("exact255_sat",  64'(sat_a), 64'd0);
    cyc();

    // Lane 1 clips
    r = fill_res(16'h0FF0);
    r[127:112] = 16'hFFFF;
    send_a(r, 8'h80);
    @(negedge clk);
    chk("clip_data", mem_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("clip_sat",  64'(sat_a), 64'd1);
    cyc();

    // start while running is ignored
    start_a = 1'b1; cyc(); start_a = 1'b0;
    @(negedge clk);
    chk("start_ignored_busy", 64'(busy_a), 64'd1);
    cyc();

    // Stream past the first row boundary
    for (int i = 0; i < 90; i++) send_a(rand_res(), 8'($urandom));
    repeat (4) cyc();
    chk("row_wrap_writes", 64'(writes_a), 64'd93);

    // Back-pressure: RAM stalls for 5 cycles while input keeps offering
    mem_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_res_a    = rand_res();
    in_carry_a  = 8'($urandom);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bit a;
      @(negedge clk);
      a = in_ready_a;
      if (a) acc_cnt++;
      cyc();
      if (a) begin
        in_res_a   = rand_res();
        in_carry_a = 8'($urandom);
      end
    end
    @(negedge clk);
    chk("bp_accepts",  64'(acc_cnt),    64'd2);
    chk("bp_in_ready", 64'(in_ready_a), 64'd0);
    chk("bp_mem_we",   64'(mem_we_a),   64'd1);
    cyc();
    in_valid_a  = 1'b0;
    mem_ready_a = 1'b1;
    repeat (4) cyc();
    chk("bp_drained", 64'(q_a.size()), 64'd0);

    // Random traffic on both sides
    for (int i = 0; i < 400; i++) begin
      in_valid_a  = ($urandom_range(0, 3) != 0);
      mem_ready_a = ($urandom_range(0, 3) != 0);
      in_res_a    = rand_res();
      in_carry_a  = 8'($urandom) & 8'($urandom);
      cyc();
    end
    in_valid_a  = 1'b0;
    mem_ready_a = 1'b1;
    repeat (5) cyc();
    chk("rand_drained", 64'(q_a.size()), 64'd0);

    // Full map on the 4x2 instance
    start_b = 1'b1; cyc(); start_b = 1'b0;
    for (int i = 0; i < TOTAL_B; i++) send_b(rand_res(), 8'($urandom));
    in_valid_b = 1'b1;
    in_res_b   = rand_res();
    begin
      int t;
      t = 0;
      while (writes_b < TOTAL_B && t < 50) begin
        cyc();
        t++;
      end
    end
    repeat (4) cyc();
    @(negedge clk);
    chk("map_writes",   64'(writes_b),   64'(TOTAL_B));
    chk("map_done_cnt", 64'(done_cnt_b), 64'd1);
    chk("map_busy",     64'(busy_b),     64'd0);
    chk("map_in_ready", 64'(in_ready_b), 64'd0);
    chk("map_addr",     64'(mem_addr_b), 64'd0);
    chk("map_mem_we",   64'(mem_we_b),   64'd0);
    cyc();
    in_valid_b = 1'b0;

    // Async reset mid-row with the FIFO full
    mem_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_res_a    = rand_res();
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready_a), 64'd0);
    chk("arst_mem_we",   64'(mem_we_a),   64'd0);
    chk("arst_mem_addr", 64'(mem_addr_a), 64'd0);
    chk("arst_mem_data", mem_data_a,      64'd0);
    chk("arst_busy",     64'(busy_a),     64'd0);
    chk("arst_sat",      64'(sat_a),      64'd0);
    in_valid_a  = 1'b0;
    mem_ready_a = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    start_a = 1'b1; cyc(); start_a = 1'b0;
    send_a(fill_res(16'h0230), 8'h00);
    @(negedge clk);
    chk("restart_addr", 64'(mem_addr_a), 64'd0);
    chk("restart_data", mem_data_a,      64'h2323_2323_2323_2323);
    cyc();
    repeat (3) cyc();

    chk("final_q_a_empty", 64'(q_a.size()), 64'd0);
    chk("final_q_b_empty", 64'(q_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
